// File: rtl/pipe_pkg.sv
// pipe_pkg: shared widths, execute-control bit positions and the hard-wired zero register index
package pipe_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int CTRL_W = 12;
    localparam int CNT_W  = 16;
    localparam logic [ADDR_W-1:0] REG_ZERO = '0;
    localparam int CTRL_ALU_OP_LSB   = 0;
    localparam int CTRL_ALU_OP_MSB   = 3;
    localparam int CTRL_ALU_SRC      = 4;
    localparam int CTRL_MEM_WRITE    = 5;
    localparam int CTRL_BRANCH       = 6;
    localparam int CTRL_JUMP         = 7;
    localparam int CTRL_MEM_SIZE_LSB = 8;
    localparam int CTRL_MEM_SIZE_MSB = 9;
    localparam int CTRL_MEM_UNSIGNED = 10;
    localparam int CTRL_LINK         = 11;
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: load-use detection between the load in EX and the instruction in ID, plus the decode stall
import pipe_pkg::*;

module hazard_detect (
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic [ADDR_W-1:0] ex_rd,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_rs,
    input  logic [ADDR_W-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic              ex_hold,
    input  logic              flush,
    output logic              lu,
    output logic              id_stall
);
    always_comb begin
        lu = ex_valid && ex_mem_read && ex_rd != REG_ZERO && id_valid &&
             (ex_rd == id_rs || (id_uses_rt && ex_rd == id_rt));
        id_stall = ex_hold || (lu && !flush);
    end
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with write-back bypass, load-use bubble, hold/flush and stall counter
import pipe_pkg::*;

module id_ex_stage (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_rs,
    input  logic [ADDR_W-1:0] id_rt,
    input  logic [ADDR_W-1:0] id_rd,
    input  logic              id_uses_rt,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              id_mem_read,
    input  logic              id_reg_write,
    input  logic [DATA_W-1:0] rf_rd1,
    input  logic [DATA_W-1:0] rf_rd2,
    input  logic              wb_write,
    input  logic [ADDR_W-1:0] wb_wr,
    input  logic [DATA_W-1:0] wb_wd,
    input  logic              ex_hold,
    input  logic              flush,
    output logic              id_stall,
    output logic              ex_valid,
    output logic              ex_mem_read,
    output logic              ex_reg_write,
    output logic [ADDR_W-1:0] ex_rs,
    output logic [ADDR_W-1:0] ex_rt,
    output logic [ADDR_W-1:0] ex_rd,
    output logic [DATA_W-1:0] ex_op_a,
    output logic [DATA_W-1:0] ex_op_b,
    output logic [DATA_W-1:0] ex_imm,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);
    logic              valid_q, valid_d, mem_read_q, mem_read_d, reg_write_q, reg_write_d;
    logic [ADDR_W-1:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
    logic [DATA_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d, imm_q, imm_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] op_a, op_b;
    logic              lu;

    hazard_detect u_hazard (
        .ex_valid   (valid_q),
        .ex_mem_read(mem_read_q),
        .ex_rd      (rd_q),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_uses_rt (id_uses_rt),
        .ex_hold    (ex_hold),
        .flush      (flush),
        .lu         (lu),
        .id_stall   (id_stall)
    );

    // bypass makes a same-edge write-back visible regardless of reg_file read/write ordering
    always_comb begin
        op_a = id_rs == REG_ZERO ? '0 : (wb_write && wb_wr == id_rs) ? wb_wd : rf_rd1;
        op_b = id_rt == REG_ZERO ? '0 : (wb_write && wb_wr == id_rt) ? wb_wd : rf_rd2;
    end

    always_comb begin
        valid_d     = valid_q;
        mem_read_d  = mem_read_q;
        reg_write_d = reg_write_q;
        rs_d        = rs_q;
        rt_d        = rt_q;
        rd_d        = rd_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        imm_d       = imm_q;
        ctrl_d      = ctrl_q;
        if (flush) begin
            valid_d     = 1'b0;
            mem_read_d  = 1'b0;
            reg_write_d = 1'b0;
            rs_d        = '0;
            rt_d        = '0;
            rd_d        = '0;
            op_a_d      = '0;
            op_b_d      = '0;
            imm_d       = '0;
            ctrl_d      = '0;
        end else if (!ex_hold && lu) begin
            valid_d     = 1'b0;
            mem_read_d  = 1'b0;
            reg_write_d = 1'b0;
            rd_d        = '0;
            ctrl_d      = '0;
        end else if (!ex_hold) begin
            valid_d     = id_valid;
            mem_read_d  = id_valid && id_mem_read;
            reg_write_d = id_valid && id_reg_write;
            rs_d        = id_rs;
            rt_d        = id_rt;
            rd_d        = id_rd;
            op_a_d      = op_a;
            op_b_d      = op_b;
            imm_d       = id_imm;
            ctrl_d      = id_valid ? id_ctrl : '0;
        end
        cnt_d = (id_stall && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            mem_read_q  <= 1'b0;
            reg_write_q <= 1'b0;
            rs_q        <= '0;
            rt_q        <= '0;
            rd_q        <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            imm_q       <= '0;
            ctrl_q      <= '0;
            cnt_q       <= '0;
        end else begin
            valid_q     <= valid_d;
            mem_read_q  <= mem_read_d;
            reg_write_q <= reg_write_d;
            rs_q        <= rs_d;
            rt_q        <= rt_d;
            rd_q        <= rd_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            imm_q       <= imm_d;
            ctrl_q      <= ctrl_d;
            cnt_q       <= cnt_d;
        end
    end

    assign ex_valid     = valid_q;
    assign ex_mem_read  = mem_read_q;
    assign ex_reg_write = reg_write_q;
    assign ex_rs        = rs_q;
    assign ex_rt        = rt_q;
    assign ex_rd        = rd_q;
    assign ex_op_a      = op_a_q;
    assign ex_op_b      = op_b_q;
    assign ex_imm       = imm_q;
    assign ex_ctrl      = ctrl_q;
    assign stall_cnt    = cnt_q;
endmodule
